// File: rtl/stop_ctrl_if.sv
// Control/status bundle between the capture path and the stop/trigger controller.
// STOP_CTRL_TRIGCNT_EN adds the trigger-occurrence count input.
interface stop_ctrl_if #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned HOLDOFF_WIDTH = 16,
    parameter int unsigned NUM_TRIG      = 8
`ifdef STOP_CTRL_TRIGCNT_EN
    ,parameter int unsigned TRIGCNT_WIDTH = 8
`endif
);
    logic                     primed;
    logic [ADDR_WIDTH-1:0]    waddr;
    logic [NUM_TRIG-1:0]      i_trig;
    logic [NUM_TRIG-1:0]      i_trig_mask;
    logic [NUM_TRIG-1:0]      i_trig_pol;
    logic                     i_trig_mode;
    logic                     i_trig_all;
    logic [HOLDOFF_WIDTH-1:0] i_holdoff;
`ifdef STOP_CTRL_TRIGCNT_EN
    logic [TRIGCNT_WIDTH-1:0] i_trig_count;
`endif
    logic                     i_rearm;
    logic                     triggered;
    logic                     stopped;
    logic [ADDR_WIDTH-1:0]    o_trig_addr;
    logic [1:0]               o_state;

    modport master (
        output primed, waddr, i_trig, i_trig_mask, i_trig_pol, i_trig_mode,
               i_trig_all, i_holdoff,
`ifdef STOP_CTRL_TRIGCNT_EN
               i_trig_count,
`endif
               i_rearm,
        input  triggered, stopped, o_trig_addr, o_state
    );

    modport slave (
        input  primed, waddr, i_trig, i_trig_mask, i_trig_pol, i_trig_mode,
               i_trig_all, i_holdoff,
`ifdef STOP_CTRL_TRIGCNT_EN
               i_trig_count,
`endif
               i_rearm,
        output triggered, stopped, o_trig_addr, o_state
    );
endinterface

// File: rtl/stop_ctrl.sv
// Stop/trigger controller: qualifies triggers once primed, runs post-trigger holdoff, then freezes capture.
// STOP_CTRL_TRIGCNT_EN enables triggering on the Nth qualified hit instead of the first.
module stop_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned HOLDOFF_WIDTH = 16,
    parameter int unsigned NUM_TRIG      = 8
`ifdef STOP_CTRL_TRIGCNT_EN
    ,parameter int unsigned TRIGCNT_WIDTH = 8
`endif
) (
    input  logic        clk,
    input  logic        reset,
    stop_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     triggered_q, triggered_d;
    logic                     stopped_q, stopped_d;
    logic [ADDR_WIDTH-1:0]    trig_addr_q, trig_addr_d;
    logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
    logic [NUM_TRIG-1:0]      x_q;

    logic [NUM_TRIG-1:0]      x;
    logic [NUM_TRIG-1:0]      hit_ch;
    logic                     hit;
    logic                     fire;

`ifdef STOP_CTRL_TRIGCNT_EN
    localparam int unsigned TCW1 = TRIGCNT_WIDTH + 1;
    logic [TRIGCNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic [TRIGCNT_WIDTH-1:0] n_eff;
    logic [TCW1-1:0]          tcnt_inc;
    logic [TRIGCNT_WIDTH-1:0] tcnt_sat;
`endif

    // Polarity-corrected channels, optional rising-edge detect, AND/OR combine
    always_comb begin
        x      = bus.i_trig ^ bus.i_trig_pol;
        hit_ch = bus.i_trig_mode ? (x & ~x_q) : x;
        hit    = 1'b0;
        if (bus.i_trig_mask != '0) begin
            if (bus.i_trig_all) hit = &(hit_ch | ~bus.i_trig_mask);
            else                hit = |(hit_ch & bus.i_trig_mask);
        end
    end

`ifdef STOP_CTRL_TRIGCNT_EN
    // Trigger fires on the hit that brings the count up to N (N=0 behaves as 1)
    always_comb begin
        n_eff    = (bus.i_trig_count == '0) ? TRIGCNT_WIDTH'(1) : bus.i_trig_count;
        tcnt_inc = {1'b0, tcnt_q} + TCW1'(1);
        tcnt_sat = (&tcnt_q) ? tcnt_q : tcnt_inc[TRIGCNT_WIDTH-1:0];
        fire     = hit && (tcnt_inc >= {1'b0, n_eff});
    end
`else
    always_comb fire = hit;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        triggered_d = triggered_q;
        stopped_d   = stopped_q;
        trig_addr_d = trig_addr_q;
        hcnt_d      = hcnt_q;
        holdoff_d   = holdoff_q;
`ifdef STOP_CTRL_TRIGCNT_EN
        tcnt_d      = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef STOP_CTRL_TRIGCNT_EN
                tcnt_d = '0;
`endif
                if (bus.primed) state_d = ARMED;
            end
            ARMED: begin
                // Losing primed takes priority over a same-cycle hit
                if (!bus.primed) begin
                    state_d = IDLE;
                end else if (fire) begin
                    state_d     = HOLDOFF;
                    triggered_d = 1'b1;
                    trig_addr_d = bus.waddr;
                    hcnt_d      = '0;
                    holdoff_d   = bus.i_holdoff;
`ifdef STOP_CTRL_TRIGCNT_EN
                end else if (hit) begin
                    tcnt_d = tcnt_sat;
`endif
                end
            end
            HOLDOFF: begin
                // Equality is reached before the counter could ever wrap
                if (hcnt_q >= holdoff_q) begin
                    state_d   = STOPPED;
                    stopped_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HOLDOFF_WIDTH'(1);
                end
            end
            STOPPED: begin
                if (bus.i_rearm) begin
                    state_d     = IDLE;
                    triggered_d = 1'b0;
                    stopped_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; edge history runs in every state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            triggered_q <= 1'b0;
            stopped_q   <= 1'b0;
            trig_addr_q <= '0;
            hcnt_q      <= '0;
            holdoff_q   <= '0;
            x_q         <= '0;
`ifdef STOP_CTRL_TRIGCNT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            triggered_q <= triggered_d;
            stopped_q   <= stopped_d;
            trig_addr_q <= trig_addr_d;
            hcnt_q      <= hcnt_d;
            holdoff_q   <= holdoff_d;
            x_q         <= x;
`ifdef STOP_CTRL_TRIGCNT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign bus.triggered   = triggered_q;
    assign bus.stopped     = stopped_q;
    assign bus.o_trig_addr = trig_addr_q;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_stop_ctrl.sv
// Directed bench for stop_ctrl: expectations are queued as stimulus is applied and checked after each edge.
module tb_stop_ctrl;
    typedef struct packed {
        logic [1:0] st;
        logic       trg;
        logic       stp;
        logic [9:0] addr;
    } exp_t;

    exp_t        sb[$];
    string       tags[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stop_ctrl_if bus ();

    stop_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            t = tags.pop_front();
            cmp(t, "state",     16'(bus.o_state),     16'(e.st));
            cmp(t, "triggered", 16'(bus.triggered),   16'(e.trg));
            cmp(t, "stopped",   16'(bus.stopped),     16'(e.stp));
            cmp(t, "trig_addr", 16'(bus.o_trig_addr), 16'(e.addr));
        end
    endtask

    // Queue the expected outputs for the current inputs, clock once, compare
    task automatic step(input string tag, input logic [1:0] st, input logic trg, input logic stp,
                        input logic [9:0] addr);
        exp_t e;
        e.st = st; e.trg = trg; e.stp = stp; e.addr = addr;
        sb.push_back(e);
        tags.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset           = 1'b0;
        bus.primed      = 1'b1;
        bus.waddr       = '0;
        bus.i_trig      = 8'h01;
        bus.i_trig_mask = 8'h01;
        bus.i_trig_pol  = 8'h00;
        bus.i_trig_mode = 1'b0;
        bus.i_trig_all  = 1'b0;
        bus.i_holdoff   = '0;
        bus.i_rearm     = 1'b0;
`ifdef STOP_CTRL_TRIGCNT_EN
        bus.i_trig_count = '0;
`endif
        @(negedge clk);

        // Reset overrides primed and an active trigger
        step("rst_a", 2'd0, 1'b0, 1'b0, 10'h000);
        step("rst_b", 2'd0, 1'b0, 1'b0, 10'h000);

        // Level trigger on ch0, holdoff 3
        bus.i_trig = 8'h00; reset = 1'b1; bus.i_holdoff = 16'd3; bus.waddr = 10'h05A;
        step("arm", 2'd1, 1'b0, 1'b0, 10'h000);
        bus.i_trig = 8'h01;
        step("trig_edge", 2'd2, 1'b1, 1'b0, 10'h05A);
        bus.i_trig = 8'h00; bus.waddr = 10'h077; bus.i_holdoff = 16'd0;
        step("ho_1", 2'd2, 1'b1, 1'b0, 10'h05A);
        step("ho_2", 2'd2, 1'b1, 1'b0, 10'h05A);
        step("ho_3", 2'd2, 1'b1, 1'b0, 10'h05A);
        step("stop_4", 2'd3, 1'b1, 1'b1, 10'h05A);
        step("stop_hold", 2'd3, 1'b1, 1'b1, 10'h05A);
        bus.i_rearm = 1'b1;
        step("rearm1", 2'd0, 1'b0, 1'b0, 10'h05A);
        bus.i_rearm = 1'b0;

        // Edge mode, AND of ch0/ch1
        bus.i_trig_mode = 1'b1; bus.i_trig_all = 1'b1; bus.i_trig_mask = 8'h03; bus.waddr = 10'h123;
        step("arm_and", 2'd1, 1'b0, 1'b0, 10'h05A);
        bus.i_trig = 8'h01;
        step("and_ch0", 2'd1, 1'b0, 1'b0, 10'h05A);
        bus.i_trig = 8'h03;
        step("and_ch1", 2'd1, 1'b0, 1'b0, 10'h05A);
        bus.i_trig = 8'h00;
        step("and_low", 2'd1, 1'b0, 1'b0, 10'h05A);
        bus.i_trig = 8'h03;
        step("and_both", 2'd2, 1'b1, 1'b0, 10'h123);
        step("and_h0", 2'd3, 1'b1, 1'b1, 10'h123);

        // Rearm with ch0 held high: no retrigger until a fresh rising edge
        bus.i_trig_mask = 8'h01; bus.i_trig_all = 1'b0; bus.i_rearm = 1'b1; bus.waddr = 10'h1AB;
        step("rearm2", 2'd0, 1'b0, 1'b0, 10'h123);
        bus.i_rearm = 1'b0;
        step("arm2", 2'd1, 1'b0, 1'b0, 10'h123);
        step("held_1", 2'd1, 1'b0, 1'b0, 10'h123);
        step("held_2", 2'd1, 1'b0, 1'b0, 10'h123);
        bus.i_trig = 8'h00;
        step("held_low", 2'd1, 1'b0, 1'b0, 10'h123);
        bus.i_trig = 8'h01;
        step("new_edge", 2'd2, 1'b1, 1'b0, 10'h1AB);
        step("new_stop", 2'd3, 1'b1, 1'b1, 10'h1AB);

        // primed drop wins over a same-cycle hit
        bus.i_rearm = 1'b1;
        step("rearm3", 2'd0, 1'b0, 1'b0, 10'h1AB);
        bus.i_rearm = 1'b0; bus.i_trig_mode = 1'b0;
        step("arm3", 2'd1, 1'b0, 1'b0, 10'h1AB);
        bus.primed = 1'b0;
        step("prim_drop", 2'd0, 1'b0, 1'b0, 10'h1AB);

        // Reset in the middle of holdoff
        bus.primed = 1'b1; bus.i_trig = 8'h00;
        step("arm4", 2'd1, 1'b0, 1'b0, 10'h1AB);
        bus.i_holdoff = 16'd5; bus.i_trig = 8'h01; bus.waddr = 10'h2CC;
        step("trig4", 2'd2, 1'b1, 1'b0, 10'h2CC);
        bus.i_trig = 8'h00;
        step("ho4", 2'd2, 1'b1, 1'b0, 10'h2CC);
        reset = 1'b0;
        step("rst_mid", 2'd0, 1'b0, 1'b0, 10'h000);
        reset = 1'b1;
        step("arm5", 2'd1, 1'b0, 1'b0, 10'h000);

        // Empty mask never triggers in either combine mode
        bus.i_trig_mask = 8'h00; bus.i_trig = 8'hFF;
        step("mask0_or", 2'd1, 1'b0, 1'b0, 10'h000);
        bus.i_trig_all = 1'b1;
        step("mask0_and", 2'd1, 1'b0, 1'b0, 10'h000);

        // Active-low channel
        bus.i_trig_all = 1'b0; bus.i_trig_mask = 8'h01; bus.i_trig_pol = 8'h01; bus.i_trig = 8'hFE;
        bus.waddr = 10'h3FF; bus.i_holdoff = 16'd0;
        step("pol_trig", 2'd2, 1'b1, 1'b0, 10'h3FF);
        step("pol_stop", 2'd3, 1'b1, 1'b1, 10'h3FF);

`ifdef STOP_CTRL_TRIGCNT_EN
        // Trigger on the third level hit
        bus.i_rearm = 1'b1;
        step("cnt_rearm", 2'd0, 1'b0, 1'b0, 10'h3FF);
        bus.i_rearm = 1'b0; bus.i_trig_pol = 8'h00; bus.i_trig = 8'h00; bus.i_trig_count = 8'd3;
        step("cnt_arm", 2'd1, 1'b0, 1'b0, 10'h3FF);
        bus.waddr = 10'h010; bus.i_trig = 8'h01;
        step("cnt_hit1", 2'd1, 1'b0, 1'b0, 10'h3FF);
        bus.i_trig = 8'h00;
        step("cnt_gap1", 2'd1, 1'b0, 1'b0, 10'h3FF);
        bus.waddr = 10'h020; bus.i_trig = 8'h01;
        step("cnt_hit2", 2'd1, 1'b0, 1'b0, 10'h3FF);
        bus.i_trig = 8'h00;
        step("cnt_gap2", 2'd1, 1'b0, 1'b0, 10'h3FF);
        bus.waddr = 10'h030; bus.i_trig = 8'h01;
        step("cnt_hit3", 2'd2, 1'b1, 1'b0, 10'h030);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
